// File: rtl/prog_loader_pkg.sv
// Shared types for the boot-time program loader: FSM state enum and
// stream/word geometry used by the loader and its word assembler.
package LoaderState;
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, DONE, ERROR} t_e;
endpackage

package Shared;
  localparam int ByteW = 8;
  localparam int WordW = 32;

  typedef LoaderState::t_e state_t;

  // States in which the loader is still consuming the stream.
  function automatic logic loading(input state_t s);
    return (s == LoaderState::HDR0) || (s == LoaderState::HDR1) ||
           (s == LoaderState::DATA) || (s == LoaderState::CHK);
  endfunction
endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs little-endian stream bytes into 32-bit words; strobe fires
// combinationally on the 4th accepted byte so the word can be registered.
module WordAssembler
  import Shared::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             accept,
  input  logic [ByteW-1:0] inData,
  output logic             strobe,
  output logic [WordW-1:0] word
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 2'd0;
      sr  <= 24'd0;
    end else if (clear) begin
      cnt <= 2'd0;
      sr  <= 24'd0;
    end else if (accept) begin
      cnt <= cnt + 2'd1;
      sr  <= {inData, sr[23:8]};
    end
  end

  // Earlier bytes have shifted down, so the live byte lands in the top lane.
  assign strobe = accept && (cnt == 2'd3);
  assign word   = {inData, sr};

endmodule

// File: rtl/prog_loader.sv
// Streams a counted, XOR-checked program image into instruction memory and
// holds the core in reset until a complete, verified image has landed.
module prog_loader
  import Shared::*;
#(
  parameter int Depth     = 32,
  parameter int AddrWidth = 30
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inValid,
  input  logic [ByteW-1:0]     inData,
  output logic                 inReady,
  input  logic                 start,
  output logic                 wEn,
  output logic [AddrWidth-1:0] wAddr,
  output logic [WordW-1:0]     wData,
  output logic                 coreReset,
  output logic                 done,
  output logic                 error
);

  localparam int IdxW = $clog2(Depth) + 1;

  LoaderState::t_e state, state_n;

  logic             accept, clear, strobe, last_word;
  logic [WordW-1:0] word;
  logic [ByteW-1:0] nlo, csum;
  logic [15:0]      nwords, hdr_n;
  logic [IdxW-1:0]  idx;

  assign inReady   = loading(state);
  assign accept    = inValid && inReady;
  assign clear     = start && ((state == LoaderState::DONE) || (state == LoaderState::ERROR));
  assign hdr_n     = {inData, nlo};
  assign last_word = (16'(idx) == nwords - 16'd1);

  WordAssembler u_asm (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .accept (accept && (state == LoaderState::DATA)),
    .inData (inData),
    .strobe (strobe),
    .word   (word)
  );

  always_comb begin
    state_n = state;
    case (state)
      LoaderState::HDR0: if (accept) state_n = LoaderState::HDR1;
      LoaderState::HDR1: if (accept) begin
        if (hdr_n == 16'd0)             state_n = LoaderState::CHK;
        else if (hdr_n > 16'(Depth))    state_n = LoaderState::ERROR;
        else                            state_n = LoaderState::DATA;
      end
      LoaderState::DATA: if (strobe && last_word) state_n = LoaderState::CHK;
      LoaderState::CHK: if (accept)
        state_n = (inData == csum) ? LoaderState::DONE : LoaderState::ERROR;
      LoaderState::DONE, LoaderState::ERROR: if (start) state_n = LoaderState::HDR0;
      default: state_n = LoaderState::HDR0;
    endcase
  end

  // Status flags are registered from the next state so they are glitch-free flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= LoaderState::HDR0;
      done      <= 1'b0;
      error     <= 1'b0;
      coreReset <= 1'b1;
    end else begin
      state     <= state_n;
      done      <= (state_n == LoaderState::DONE);
      error     <= (state_n == LoaderState::ERROR);
      coreReset <= (state_n != LoaderState::DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx    <= '0;
      csum   <= '0;
      nlo    <= '0;
      nwords <= '0;
      wEn    <= 1'b0;
      wAddr  <= '0;
      wData  <= '0;
    end else begin
      wEn <= 1'b0;
      if (clear) begin
        idx  <= '0;
        csum <= '0;
      end
      // The checksum byte itself is compared, not folded in.
      if (accept && (state != LoaderState::CHK)) csum <= csum ^ inData;
      if (accept && (state == LoaderState::HDR0)) nlo <= inData;
      if (accept && (state == LoaderState::HDR1)) nwords <= hdr_n;
      if (strobe) begin
        wEn   <= 1'b1;
        wData <= word;
        wAddr <= AddrWidth'(idx);
        idx   <= idx + 1'b1;
      end
    end
  end

endmodule
